// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and sizing helpers for the APB wait-state slave
package apb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  function automatic int cnt_w(input int ws);
    return ws < 1 ? 1 : $clog2(ws + 1);
  endfunction
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/apb_mem_bank.sv
// apb_mem_bank: byte-enabled write port plus registered read port that doubles as prdata
module apb_mem_bank
  import apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [DATA_W-1:0]           w_data,
  input  logic [strb_w(DATA_W)-1:0]   strb,
  input  logic                        rd_en,
  input  logic                        rd_clr,
  input  logic [AW-1:0]               rd_addr,
  output logic [DATA_W-1:0]           rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < strb_w(DATA_W); i++)
        if (strb[i]) mem[wr_addr][8*i +: 8] <= w_data[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else if (rd_clr) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/apb_slave_ws.sv
// apb_slave_ws: APB3 memory slave with programmable wait states, byte strobes and range error
module apb_slave_ws
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     rw_addr,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [DATA_W/8-1:0]   strb,
  output logic                  ready,
  output logic [DATA_W-1:0]     prdata,
  output logic                  slverr
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(WAIT_STATES);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q, eaddr;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W/8-1:0] strb_q;
  logic wr_q, ewr, err, eval, latch, ready_n, slverr_n;
  // With zero wait states the response is evaluated at the setup edge, so use the live bus
  assign eaddr = state == IDLE ? rw_addr : addr_q;
  assign ewr   = state == IDLE ? pwrite : wr_q;
  assign err   = {1'b0, eaddr} >= (ADDR_W+1)'(DEPTH);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      slverr  <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ready  <= ready_n;
      slverr <= slverr_n;
      if (latch) begin
        addr_q  <= rw_addr;
        wr_q    <= pwrite;
        wdata_q <= w_data;
        strb_q  <= strb;
      end
    end
  end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ready_n  = ready;
    slverr_n = slverr;
    eval     = 1'b0;
    latch    = 1'b0;
    case (state)
      IDLE: if (sel) begin
        latch   = 1'b1;
        state_n = ACCESS;
        cnt_n   = CW'(WAIT_STATES);
        ready_n = WAIT_STATES == 0;
        eval    = WAIT_STATES == 0;
      end
      ACCESS: if (!sel) begin
        state_n  = IDLE;
        ready_n  = 1'b0;
        slverr_n = 1'b0;
      end else if (ready) begin
        if (enable) begin
          state_n  = DONE;
          ready_n  = 1'b0;
          slverr_n = 1'b0;
        end
      end else begin
        cnt_n   = cnt - 1'b1;
        ready_n = cnt == CW'(1);
        eval    = ready_n;
      end
      default: state_n = IDLE;
    endcase
    if (eval) slverr_n = err;
  end
  apb_mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (state == ACCESS && ready && sel && enable && wr_q && !slverr),
    .wr_addr (addr_q[AW-1:0]),
    .w_data  (wdata_q),
    .strb    (strb_q),
    .rd_en   (eval && !err && !ewr),
    .rd_clr  (eval && err),
    .rd_addr (eaddr[AW-1:0]),
    .rd_data (prdata)
  );
endmodule

// File: tb/tb_apb_slave_ws.sv
// tb_apb_slave_ws: scoreboard bench driving a zero-wait and a three-wait slave instance
module tb_apb_slave_ws;
  typedef struct {
    bit          chk_d;
    logic [31:0] d;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        sel[2], enable[2], pwrite[2], ready[2], slverr[2];
  logic [7:0]  rw_addr[2];
  logic [31:0] w_data[2], prdata[2];
  logic [3:0]  strb[2];
  exp_t q0[$], q1[$];
  int n_vec = 0, n_bad = 0;
  bit prev[2] = '{1'b0, 1'b0};
  always #5 clk = ~clk;
  apb_slave_ws #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .sel(sel[0]), .enable(enable[0]), .pwrite(pwrite[0]),
    .rw_addr(rw_addr[0]), .w_data(w_data[0]), .strb(strb[0]),
    .ready(ready[0]), .prdata(prdata[0]), .slverr(slverr[0]));
  apb_slave_ws #(.WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst), .sel(sel[1]), .enable(enable[1]), .pwrite(pwrite[1]),
    .rw_addr(rw_addr[1]), .w_data(w_data[1]), .strb(strb[1]),
    .ready(ready[1]), .prdata(prdata[1]), .slverr(slverr[1]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input int d, input bit chk_d, input logic [31:0] v, input logic err);
    exp_t e;
    e.chk_d = chk_d;
    e.d = v;
    e.err = err;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic setup(input int d, input bit wr, input logic [7:0] a, input logic [31:0] dat,
                       input logic [3:0] s);
    sel[d] = 1'b1; enable[d] = 1'b0; pwrite[d] = wr;
    rw_addr[d] = a; w_data[d] = dat; strb[d] = s;
    @(posedge clk); #1;
    enable[d] = 1'b1; pwrite[d] = ~wr;
    rw_addr[d] = ~a; w_data[d] = ~dat; strb[d] = ~s;
  endtask
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] dat,
                      input logic [3:0] s, input logic [31:0] exp_d, input logic exp_e);
    int w;
    push(d, !wr, exp_d, exp_e);
    setup(d, wr, a, dat, s);
    w = 0;
    while (!ready[d] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk($sformatf("wait_cycles dut%0d addr %0d", d, a), 32'(w), d == 0 ? 32'd0 : 32'd3);
    @(posedge clk); #1;
    sel[d] = 1'b0; enable[d] = 1'b0;
    @(posedge clk); #1;
  endtask
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (ready[d] && !prev[d]) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_ready dut%0d: got ready 1 expected no response", d);
        end else begin
          exp_t e;
          e = d == 0 ? q0.pop_front() : q1.pop_front();
          chk($sformatf("slverr dut%0d", d), 32'(slverr[d]), 32'(e.err));
          if (e.chk_d) chk($sformatf("prdata dut%0d", d), prdata[d], e.d);
        end
      end
      prev[d] = ready[d];
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      sel[d] = 0; enable[d] = 0; pwrite[d] = 0; rw_addr[d] = 0; w_data[d] = 0; strb[d] = 0;
    end
    #2 rst = 1'b0;
    #20 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
        chk($sformatf("idle dut%0d cyc%0d rdy/err/prdata", d, i),
            {ready[d], slverr[d], prdata[d][29:0]}, 32'h0);
    end
    xfer(0, 1, 8'd5, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xfer(0, 0, 8'd5, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    xfer(0, 1, 8'd5, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    xfer(0, 0, 8'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    xfer(0, 1, 8'd5, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(0, 0, 8'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    xfer(0, 1, 8'd6, 32'h66666666, 4'hF, 32'h0, 1'b0);
    xfer(0, 1, 8'd70, 32'h0BADF00D, 4'hF, 32'h0, 1'b1);
    xfer(0, 0, 8'd70, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 0, 8'd6, 32'h0, 4'h0, 32'h66666666, 1'b0);
    xfer(0, 0, 8'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    xfer(1, 1, 8'd5, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xfer(1, 0, 8'd5, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    xfer(1, 1, 8'd9, 32'hA5A50009, 4'hF, 32'h0, 1'b0);
    setup(1, 1, 8'd9, 32'h00000000, 4'hF);
    @(posedge clk); #1;
    sel[1] = 1'b0; enable[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort ready dut1", 32'(ready[1]), 32'h0);
    xfer(1, 0, 8'd9, 32'h0, 4'h0, 32'hA5A50009, 1'b0);
    xfer(0, 1, 8'd9, 32'h12345678, 4'hF, 32'h0, 1'b0);
    xfer(0, 0, 8'd5, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
    push(0, 1'b0, 32'h0, 1'b0);
    setup(0, 1, 8'd9, 32'hFFFFFFFF, 4'hF);
    chk("pre_reset ready dut0", 32'(ready[0]), 32'h1);
    #3 rst = 1'b0;
    #1;
    chk("reset ready dut0", 32'(ready[0]), 32'h0);
    chk("reset slverr dut0", 32'(slverr[0]), 32'h0);
    chk("reset prdata dut0", prdata[0], 32'h0);
    @(posedge clk); #1;
    sel[0] = 1'b0; enable[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0, 8'd9, 32'h0, 4'h0, 32'h12345678, 1'b0);
    xfer(1, 0, 8'd5, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained dut0", 32'(q0.size()), 32'h0);
    chk("scoreboard drained dut1", 32'(q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
